cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
Parametrised fetch/decode/execute control unit for the 8-bit CPU family, generalising the fixed 4-op, 3-bit-address controller.
- Owns the program counter and issues instruction-memory requests with a valid handshake.
- Drives register-file addresses and write enables, and launches multi-cycle ALU operations with a start/done handshake.
- Maintains a registered zero flag and supports a HALT instruction.

Parameters:
REG_AW, 3, register-file address width (2**REG_AW registers)
OPC_W, 2, opcode field width (MSBs of instruction)
PC_W, 8, program counter / imem address width
INSTR_W, OPC_W+2*REG_AW, derived localparam; instruction = {opc, ra, rb}

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  level; enables leaving S_IDLE
imem_req  out  1  fetch request, held until imem_valid
imem_addr  out  PC_W  fetch address (= pc)
imem_valid  in  1  imem_rdata valid this cycle
imem_rdata  in  INSTR_W  fetched instruction
rf_addr_a  out  REG_AW  operand/destination A (instr ra field)
rf_addr_b  out  REG_AW  operand B (instr rb field)
rf_we_a  out  1  write-enable, register A
rf_we_b  out  1  write-enable, register B (SWAP only)
alu_op  out  3  ALU function code (pkg enum)
alu_start  out  1  single-cycle pulse launching ALU
alu_done  in  1  ALU result valid (>=1 cycle after start)
alu_zero  in  1  ALU result==0, sampled with alu_done
flag_zero  out  1  registered zero flag
pc  out  PC_W  program counter
state  out  4  current state encoding (debug)
halted  out  1  high in S_HALT

Behaviour:
- Reset (rst_n low, async): state=S_IDLE, pc=0, instruction register=0, flag_zero=0. All strobes (imem_req, alu_start, rf_we_a/b) are 0, halted=0. rf_addr_* come from the IR, so they are 0.
- States: S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ALU_WAIT, S_WB, S_WB2, S_HALT.
- S_IDLE: goes to S_FETCH when run=1, else stays.
- S_FETCH: imem_req=1.
  - On imem_valid: IR<=imem_rdata, pc<=pc+1 (wraps mod 2**PC_W), go to S_DECODE.
  - With no valid, stays; no timeout.
- S_DECODE: opc 01=ADD, 10=SUB, 11=SWAP, 00=ONE class with sub-op in rb.
  - ONE sub-ops: 000 NOP, 001 INC, 010 DEC, 011 NOT, 111 HALT, others = NOP.
  - NOP goes to S_FETCH when run=1, else S_IDLE.
  - HALT goes to S_HALT.
  - SWAP goes to S_WB.
  - All other ops go to S_EXEC.
- S_EXEC: alu_start=1 for exactly one cycle, alu_op valid; next state S_ALU_WAIT.
- S_ALU_WAIT: alu_op held.
  - On alu_done: flag_zero<=alu_zero, rf_we_a=1 in that same cycle (result written to ra).
  - Then to S_FETCH if run=1, else S_IDLE.
- SWAP: S_WB asserts rf_we_a (A<=B), S_WB2 asserts rf_we_b (B<=old A, register file holds the temp). Neither step touches flag_zero. Afterwards to S_FETCH or S_IDLE per run.
- S_HALT: halted=1; leaves only via reset.
- run deasserting mid-instruction: the instruction completes and the block parks in S_IDLE at the boundary.
- alu_done outside S_ALU_WAIT is ignored. imem_valid outside S_FETCH is ignored.
- Latency: NOP = 2 cycles, ALU op = 4+N cycles (N = ALU wait cycles beyond the first), SWAP = 4 cycles, with a zero-wait imem.
- rst_n asserted mid-operation: immediate return to reset values; no write strobes in that cycle.

Optional Feature:
CPU_CTRL_PERF_EN
- Defined: adds outputs cyc_cnt[31:0] and retired_cnt[31:0].
  - cyc_cnt counts cycles while state!=S_IDLE and !=S_HALT.
  - retired_cnt increments at each instruction completion, including HALT.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither port nor logic exists; behaviour is otherwise identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state_t enum (4-bit, S_IDLE=0 upward in listed order)
  - opc_t (ONE/ADD/SUB/SWAP)
  - one_sub_t codes
  - alu_op_t (ADD=0, SUB=1, INC=2, DEC=3, NOT=4)
- Sub-module cpu_ctrl_decode: purely combinational IR -> {alu_op, next class, is_halt, is_nop}. The FSM and PC stay in the top module.

Test Plan:
- Reset then run=1, imem returns 8'b01_001_010 with 0 wait, alu_done 1 cycle after start, alu_zero=0 -> rf_addr_a=1, rf_addr_b=2, alu_op=ADD, single alu_start pulse, rf_we_a at done, pc=1, flag_zero=0.
- SUB 8'b10_011_011 with alu_zero=1 and 3 wait cycles -> alu_op held through wait, flag_zero=1 after done, rf_we_a pulsed once.
- SWAP 8'b11_000_101 -> rf_we_a then rf_we_b on consecutive cycles, no alu_start, flag_zero unchanged.
- HALT 8'b00_000_111 -> halted=1, imem_req stays 0 for 20 cycles with run=1; rst_n low restores S_IDLE, pc=0.
- imem_valid delayed 5 cycles, with run dropped during S_ALU_WAIT -> imem_req held 5 cycles, instruction completes, state=S_IDLE; pc wraps 255->0 when PC_W=8.
- rst_n pulsed low during S_ALU_WAIT -> no rf_we, all outputs at reset values asynchronously. With CPU_CTRL_PERF_EN, retired_cnt=0 after reset and increments once per completed instruction.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and helpers for the cpu_ctrl_fsm fetch/decode/execute controller.
// Revision: 1.0
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_ALU_WAIT = 4'd4,
    S_WB       = 4'd5,
    S_WB2      = 4'd6,
    S_HALT     = 4'd7
  } state_t;

  typedef enum logic [1:0] {
    OPC_ONE  = 2'b00,
    OPC_ADD  = 2'b01,
    OPC_SUB  = 2'b10,
    OPC_SWAP = 2'b11
  } opc_t;

  typedef enum logic [2:0] {
    ONE_NOP  = 3'b000,
    ONE_INC  = 3'b001,
    ONE_DEC  = 3'b010,
    ONE_NOT  = 3'b011,
    ONE_HALT = 3'b111
  } one_sub_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_INC = 3'd2,
    ALU_DEC = 3'd3,
    ALU_NOT = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    CLS_NOP  = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_SWAP = 2'd2,
    CLS_HALT = 2'd3
  } cls_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: instruction-memory, register-file and ALU handshake bundle of the controller.
// Revision: 1.0
`default_nettype none

interface cpu_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int OPC_W  = 2,
  parameter int PC_W   = 8
);
  import cpu_ctrl_pkg::*;

  localparam int INSTR_W = OPC_W + 2 * REG_AW;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;
  logic [REG_AW-1:0]  rf_addr_a;
  logic [REG_AW-1:0]  rf_addr_b;
  logic               rf_we_a;
  logic               rf_we_b;
  alu_op_t            alu_op;
  logic               alu_start;
  logic               alu_done;
  logic               alu_zero;

  modport master (
    output imem_req, imem_addr, rf_addr_a, rf_addr_b, rf_we_a, rf_we_b, alu_op, alu_start,
    input  imem_valid, imem_rdata, alu_done, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr, rf_addr_a, rf_addr_b, rf_we_a, rf_we_b, alu_op, alu_start,
    output imem_valid, imem_rdata, alu_done, alu_zero
  );

endinterface

`default_nettype wire

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: combinational opcode/sub-op decode into ALU function and instruction class.
// Revision: 1.0
`default_nettype none

module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int OPC_W  = 2
) (
  input  logic [OPC_W-1:0]  opc,
  input  logic [REG_AW-1:0] rb,
  output alu_op_t           alu_op,
  output cls_t              cls,
  output logic              is_halt,
  output logic              is_nop
);

  always_comb begin
    alu_op  = ALU_ADD;
    cls     = CLS_NOP;
    is_halt = 1'b0;
    is_nop  = 1'b0;
    case (opc)
      OPC_W'(OPC_ADD): begin
        cls    = CLS_ALU;
        alu_op = ALU_ADD;
      end
      OPC_W'(OPC_SUB): begin
        cls    = CLS_ALU;
        alu_op = ALU_SUB;
      end
      OPC_W'(OPC_SWAP): begin
        cls = CLS_SWAP;
      end
      OPC_W'(OPC_ONE): begin
        // The rb field carries the sub-op; undefined codes behave as NOP
        case (rb)
          REG_AW'(ONE_INC): begin
            cls    = CLS_ALU;
            alu_op = ALU_INC;
          end
          REG_AW'(ONE_DEC): begin
            cls    = CLS_ALU;
            alu_op = ALU_DEC;
          end
          REG_AW'(ONE_NOT): begin
            cls    = CLS_ALU;
            alu_op = ALU_NOT;
          end
          REG_AW'(ONE_HALT): begin
            cls     = CLS_HALT;
            is_halt = 1'b1;
          end
          default: begin
            cls    = CLS_NOP;
            is_nop = 1'b1;
          end
        endcase
      end
      default: begin
        cls    = CLS_NOP;
        is_nop = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: fetch/decode/execute controller owning PC, IR and zero flag; perf counters via CPU_CTRL_PERF_EN.
// Revision: 1.0
`default_nettype none

module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int OPC_W  = 2,
  parameter int PC_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  cpu_ctrl_if.master       bus,
  output logic             flag_zero,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       state,
  output logic             halted
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [31:0]      cyc_cnt,
  output logic [31:0]      retired_cnt
`endif
);

  localparam int INSTR_W = OPC_W + 2 * REG_AW;

  state_t             r_state;
  state_t             w_next;
  logic [INSTR_W-1:0] r_ir;
  logic [PC_W-1:0]    r_pc;
  logic               r_flag;
  logic               w_alu_fin;
  alu_op_t            w_alu_op;
  cls_t               w_cls;
  logic               w_is_halt;
  logic               w_is_nop;

  cpu_ctrl_decode #(
    .REG_AW (REG_AW),
    .OPC_W  (OPC_W)
  ) u_decode (
    .opc     (r_ir[INSTR_W-1 -: OPC_W]),
    .rb      (r_ir[REG_AW-1:0]),
    .alu_op  (w_alu_op),
    .cls     (w_cls),
    .is_halt (w_is_halt),
    .is_nop  (w_is_nop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_pc    <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && bus.imem_valid) begin
        r_ir <= bus.imem_rdata;
        r_pc <= r_pc + PC_W'(1);
      end
      if (w_alu_fin) begin
        r_flag <= bus.alu_zero;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.imem_req  = 1'b0;
    bus.alu_start = 1'b0;
    bus.rf_we_a   = 1'b0;
    bus.rf_we_b   = 1'b0;
    w_alu_fin     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_halt)             w_next = S_HALT;
        else if (w_is_nop)         w_next = run ? S_FETCH : S_IDLE;
        else if (w_cls == CLS_SWAP) w_next = S_WB;
        else                       w_next = S_EXEC;
      end
      S_EXEC: begin
        bus.alu_start = 1'b1;
        w_next        = S_ALU_WAIT;
      end
      S_ALU_WAIT: begin
        if (bus.alu_done) begin
          bus.rf_we_a = 1'b1;
          w_alu_fin   = 1'b1;
          w_next      = run ? S_FETCH : S_IDLE;
        end
      end
      // Two-step swap: A<=B first, then B<=old A held by the register file
      S_WB: begin
        bus.rf_we_a = 1'b1;
        w_next      = S_WB2;
      end
      S_WB2: begin
        bus.rf_we_b = 1'b1;
        w_next      = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign bus.imem_addr = r_pc;
  assign bus.rf_addr_a = r_ir[2*REG_AW-1:REG_AW];
  assign bus.rf_addr_b = r_ir[REG_AW-1:0];
  assign bus.alu_op    = w_alu_op;
  assign flag_zero     = r_flag;
  assign pc            = r_pc;
  assign state         = r_state;
  assign halted        = (r_state == S_HALT);

`ifdef CPU_CTRL_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_retired_cnt;
  logic        w_retire;

  assign w_retire = (r_state == S_DECODE && (w_is_nop || w_is_halt)) ||
                    w_alu_fin || (r_state == S_WB2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt     <= '0;
      r_retired_cnt <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_HALT) r_cyc_cnt <= sat_inc32(r_cyc_cnt);
      if (w_retire) r_retired_cnt <= sat_inc32(r_retired_cnt);
    end
  end

  assign cyc_cnt     = r_cyc_cnt;
  assign retired_cnt = r_retired_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed scoreboard bench for cpu_ctrl_fsm with reactive imem and ALU models.
// Revision: 1.0
`default_nettype none

module tb_cpu_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  localparam int REG_AW = 3;
  localparam int OPC_W  = 2;
  localparam int PC_W   = 8;
  localparam int K_START = 0;
  localparam int K_WEA   = 1;
  localparam int K_WEB   = 2;

  typedef struct {
    int         kind;
    logic [2:0] a;
    logic [2:0] b;
    logic       chk_op;
    alu_op_t    op;
  } ev_t;

  ev_t exp_q[$];

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            run   = 1'b0;
  logic            flag_zero;
  logic            halted;
  logic [PC_W-1:0] pc;
  logic [3:0]      state;
`ifdef CPU_CTRL_PERF_EN
  logic [31:0]     cyc_cnt;
  logic [31:0]     retired_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] cfg_instr     = 8'h00;
  int         cfg_imem_wait = 0;
  int         cfg_alu_wait  = 0;
  logic       cfg_zero      = 1'b0;

  cpu_ctrl_if #(.REG_AW(REG_AW), .OPC_W(OPC_W), .PC_W(PC_W)) bus ();

  cpu_ctrl_fsm #(.REG_AW(REG_AW), .OPC_W(OPC_W), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .bus       (bus),
    .flag_zero (flag_zero),
    .pc        (pc),
    .state     (state),
    .halted    (halted)
`ifdef CPU_CTRL_PERF_EN
    ,
    .cyc_cnt     (cyc_cnt),
    .retired_cnt (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Instruction memory: answers a held request after cfg_imem_wait idle cycles
  int req_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (bus.imem_req) begin
      if (req_cnt >= cfg_imem_wait) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = cfg_instr;
      end else begin
        bus.imem_valid = 1'b0;
      end
      req_cnt++;
    end else begin
      bus.imem_valid = 1'b0;
      req_cnt = 0;
    end
  end

  // ALU: done arrives cfg_alu_wait cycles after the first cycle following start
  logic alu_busy = 1'b0;
  int   alu_cnt  = 0;
  always @(posedge clk) begin
    #1;
    bus.alu_done = 1'b0;
    if (bus.alu_start) begin
      alu_busy = 1'b1;
      alu_cnt  = 0;
    end else if (alu_busy) begin
      if (alu_cnt >= cfg_alu_wait) begin
        bus.alu_done = 1'b1;
        bus.alu_zero = cfg_zero;
        alu_busy     = 1'b0;
      end else begin
        alu_cnt++;
      end
    end
  end

  alu_op_t cur_op = ALU_ADD;

  task automatic take(int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_strobe: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("strobe_kind", kind, e.kind);
      chk("rf_addr_a", 32'(bus.rf_addr_a), 32'(e.a));
      chk("rf_addr_b", 32'(bus.rf_addr_b), 32'(e.b));
      if (e.chk_op) chk("alu_op", 32'(bus.alu_op), 32'(e.op));
      if (kind == K_START) cur_op = e.op;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.alu_start) take(K_START);
      if (bus.rf_we_a)   take(K_WEA);
      if (bus.rf_we_b)   take(K_WEB);
      if (state == S_ALU_WAIT) chk("alu_op_held", 32'(bus.alu_op), 32'(cur_op));
    end
  end

  task automatic push(int kind, logic [2:0] a, logic [2:0] b, logic c, alu_op_t op);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.chk_op = c; e.op = op;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(state_t s, int budget, string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state != s && n < budget);
    if (state != s) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: state %0d expected %0d", name, state, s);
    end
  endtask

  task automatic do_instr(logic [7:0] instr, int aw, logic z, string name);
    cfg_instr = instr; cfg_imem_wait = 0; cfg_alu_wait = aw; cfg_zero = z;
    run = 1'b1;
    wait_state(S_DECODE, 20, name);
    run = 1'b0;
    wait_state(S_IDLE, 40, name);
  endtask

  task automatic chk_ret(int exp);
`ifdef CPU_CTRL_PERF_EN
    chk("retired_cnt", retired_cnt, 32'(exp));
`else
    if (exp < 0) $display("negative retire expectation");
`endif
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_state"},   32'(state), 32'(S_IDLE));
    chk({tag, "_pc"},      32'(pc), 32'd0);
    chk({tag, "_flag"},    32'(flag_zero), 32'd0);
    chk({tag, "_halted"},  32'(halted), 32'd0);
    chk({tag, "_req"},     32'(bus.imem_req), 32'd0);
    chk({tag, "_start"},   32'(bus.alu_start), 32'd0);
    chk({tag, "_we_a"},    32'(bus.rf_we_a), 32'd0);
    chk({tag, "_we_b"},    32'(bus.rf_we_b), 32'd0);
    chk({tag, "_addr_a"},  32'(bus.rf_addr_a), 32'd0);
    chk({tag, "_addr_b"},  32'(bus.rf_addr_b), 32'd0);
  endtask

  initial begin
    int n;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    bus.alu_done   = 1'b0;
    bus.alu_zero   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk_ret(0);
    rst_n = 1'b1;

    // ADD r1,r2 with a one-cycle ALU
    push(K_START, 3'd1, 3'd2, 1'b1, ALU_ADD);
    push(K_WEA,   3'd1, 3'd2, 1'b1, ALU_ADD);
    do_instr(8'b01_001_010, 0, 1'b0, "add");
    chk("add_pc", 32'(pc), 32'd1);
    chk("add_flag", 32'(flag_zero), 32'd0);

    // SUB r3,r3 with three extra wait cycles, zero result
    push(K_START, 3'd3, 3'd3, 1'b1, ALU_SUB);
    push(K_WEA,   3'd3, 3'd3, 1'b1, ALU_SUB);
    do_instr(8'b10_011_011, 3, 1'b1, "sub");
    chk("sub_pc", 32'(pc), 32'd2);
    chk("sub_flag", 32'(flag_zero), 32'd1);

    // SWAP r0,r5 leaves the flag alone
    push(K_WEA, 3'd0, 3'd5, 1'b0, ALU_ADD);
    push(K_WEB, 3'd0, 3'd5, 1'b0, ALU_ADD);
    do_instr(8'b11_000_101, 0, 1'b0, "swap");
    chk("swap_pc", 32'(pc), 32'd3);
    chk("swap_flag", 32'(flag_zero), 32'd1);

    // NOT r2 clears the flag
    push(K_START, 3'd2, 3'd3, 1'b1, ALU_NOT);
    push(K_WEA,   3'd2, 3'd3, 1'b1, ALU_NOT);
    do_instr(8'b00_010_011, 1, 1'b0, "not");
    chk("not_flag", 32'(flag_zero), 32'd0);

    // Undefined ONE sub-op behaves as NOP
    do_instr(8'b00_001_100, 0, 1'b1, "nop");
    chk("nop_pc", 32'(pc), 32'd5);
    chk("nop_flag", 32'(flag_zero), 32'd0);

    // HALT with run held high
    cfg_instr = 8'b00_000_111;
    run = 1'b1;
    wait_state(S_HALT, 20, "halt");
    chk("halted", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd6);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.imem_req) n++;
    end
    chk("halt_no_fetch", 32'(n), 32'd0);
    chk("halt_state", 32'(state), 32'(S_HALT));
    chk_ret(6);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("halt_rst");
    chk_ret(0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream NOPs until pc reaches 255, then a slow-imem DEC that wraps pc
    cfg_instr = 8'h00; cfg_imem_wait = 0;
    n = 0;
    while (pc != 8'd255 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("pc_reach_255", 32'(pc), 32'd255);
    cfg_instr = 8'b00_100_010; cfg_imem_wait = 5; cfg_alu_wait = 2; cfg_zero = 1'b1;
    push(K_START, 3'd4, 3'd2, 1'b1, ALU_DEC);
    push(K_WEA,   3'd4, 3'd2, 1'b1, ALU_DEC);
    wait_state(S_FETCH, 5, "wrap_fetch");
    n = 0;
    while (bus.imem_req && !bus.imem_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("imem_wait_cycles", 32'(n), 32'd5);
    chk("imem_req_at_valid", 32'(bus.imem_req & bus.imem_valid), 32'd1);
    wait_state(S_ALU_WAIT, 10, "wrap_alu");
    run = 1'b0;
    wait_state(S_IDLE, 20, "wrap_idle");
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_flag", 32'(flag_zero), 32'd1);
    chk_ret(256);

    // Reset during a long ALU wait: nothing is written
    push(K_START, 3'd7, 3'd6, 1'b1, ALU_ADD);
    cfg_instr = 8'b01_111_110; cfg_imem_wait = 0; cfg_alu_wait = 10; cfg_zero = 1'b0;
    run = 1'b1;
    wait_state(S_DECODE, 20, "rst_dec");
    run = 1'b0;
    wait_state(S_ALU_WAIT, 10, "rst_alu");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    chk_ret(0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_state", 32'(state), 32'(S_IDLE));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
